// File: rtl/m_axi_write_master.sv
// AXI4 single-beat write initiator.
// Takes one command at a time, drives AW/W until each handshakes, then waits on B.
// A B-channel timeout turns a missing response into SLVERR with timeout_o set.
module m_axi_write_master #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4
) (
  input  logic              clk,
  input  logic              areset,
  // Command port
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ID_W-1:0]   cmd_id_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  // AW channel
  output logic [ID_W-1:0]   awid_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  // W channel
  output logic [DATA_W-1:0] wdata_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  // B channel
  input  logic [ID_W-1:0]   bid_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  // Completion report
  output logic              done_o,
  output logic [1:0]        resp_o,
  output logic              id_err_o,
  output logic              timeout_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSend  = 2'd1;
  localparam logic [1:0] StWaitB = 2'd2;

  // Width covers 0..TIMEOUT; a 1-bit dummy keeps the counter legal when disabled.
  localparam int unsigned   CntW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;
  localparam bit            TimeoutEn = (TIMEOUT != 0);

  logic [1:0]        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [ID_W-1:0]   awid_q, awid_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              bready_q, bready_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [1:0]        resp_q, resp_d;
  logic              id_err_q, id_err_d;
  logic              timeout_q, timeout_d;

  logic aw_hs, w_hs;

  assign aw_hs = awvalid_q & awready_i;
  assign w_hs  = wvalid_q & wready_i;

  // Next-state logic for the transaction FSM and all registered outputs.
  always_comb begin
    state_d   = state_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    resp_d    = resp_q;
    id_err_d  = id_err_q;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_q) begin
          awid_d    = cmd_id_i;
          awaddr_d  = cmd_addr_i;
          wdata_d   = cmd_data_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          cnt_d    = '0;
          state_d  = StWaitB;
        end
      end
      StWaitB: begin
        cnt_d = cnt_q + 1'b1;
        // A real response in the expiry cycle takes priority over the timeout.
        if (bvalid_i) begin
          resp_d    = bresp_i;
          id_err_d  = (bid_i != awid_q);
          timeout_d = 1'b0;
          done_d    = 1'b1;
          bready_d  = 1'b0;
          state_d   = StIdle;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          resp_d    = 2'b10;
          id_err_d  = 1'b0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          bready_d  = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered ready keeps it low while reset is asserted and for the first edge after.
    cmd_ready_d = (state_d == StIdle);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      awid_q      <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      resp_q      <= 2'b00;
      id_err_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awid_q      <= awid_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      resp_q      <= resp_d;
      id_err_q    <= id_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign awid_o      = awid_q;
  assign awaddr_o    = awaddr_q;
  assign awvalid_o   = awvalid_q;
  assign wdata_o     = wdata_q;
  assign wvalid_o    = wvalid_q;
  assign bready_o    = bready_q;
  assign done_o      = done_q;
  assign resp_o      = resp_q;
  assign id_err_o    = id_err_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_m_axi_write_master.sv
// Bench for m_axi_write_master: stimulus pushes expected completions into a queue,
// an independent monitor pops and compares on every done_o.
module tb_m_axi_write_master;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready_o;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  awid_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o;
  logic        awready;
  logic [31:0] wdata_o;
  logic        wvalid_o;
  logic        wready;
  logic [3:0]  bid_r;
  logic [1:0]  bresp_r;
  logic        bvalid;
  logic        bready_o;
  logic        done_o;
  logic [1:0]  resp_o;
  logic        id_err_o;
  logic        timeout_o;

  m_axi_write_master #(
    .TIMEOUT(TO),
    .ADDR_W (32),
    .DATA_W (32),
    .ID_W   (4)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready_o),
    .cmd_id_i   (cmd_id),
    .cmd_addr_i (cmd_addr),
    .cmd_data_i (cmd_data),
    .awid_o     (awid_o),
    .awaddr_o   (awaddr_o),
    .awvalid_o  (awvalid_o),
    .awready_i  (awready),
    .wdata_o    (wdata_o),
    .wvalid_o   (wvalid_o),
    .wready_i   (wready),
    .bid_i      (bid_r),
    .bresp_i    (bresp_r),
    .bvalid_i   (bvalid),
    .bready_o   (bready_o),
    .done_o     (done_o),
    .resp_o     (resp_o),
    .id_err_o   (id_err_o),
    .timeout_o  (timeout_o)
  );

  typedef struct {
    logic [1:0] resp;
    logic       id_err;
    logic       to;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  endtask

  task automatic bail(input string name);
    fails++;
    $display("FAIL %s bound expired (cycle %0d)", name, cyc);
    summary_and_finish();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready_o !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 100) bail("cmd_ready_wait");
    end
  endtask

  // One complete write; awd/wd are ready delays, bd >= TO means the slave never responds.
  task automatic do_txn(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                        input int awd, input int wd, input int bd,
                        input logic [1:0] bresp, input logic [3:0] bid);
    int   entry;
    bit   aw_ok, w_ok;
    int   aw_cnt, w_cnt;
    exp_t e;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_data  = data;
    // Accept edge follows this cycle; SEND spans max(awd,wd)+1 cycles.
    entry = cyc + 2 + ((awd > wd) ? awd : wd);
    if (bd < int'(TO)) begin
      e.resp = bresp; e.id_err = (bid != id); e.to = 1'b0; e.cyc = entry + bd + 1;
    end else begin
      e.resp = 2'b10; e.id_err = 1'b0; e.to = 1'b1; e.cyc = entry + int'(TO);
    end
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_id    = 4'($urandom);
    cmd_addr  = $urandom;
    cmd_data  = $urandom;
    chk("cmd_ready_busy", 64'(cmd_ready_o), 64'd0);
    aw_ok = 0; w_ok = 0; aw_cnt = 0; w_cnt = 0;
    while (!(aw_ok && w_ok)) begin
      chk("bready_in_send", 64'(bready_o), 64'd0);
      if (!aw_ok) begin
        chk("awvalid_hold", 64'(awvalid_o), 64'd1);
        chk("awid", 64'(awid_o), 64'(id));
        chk("awaddr", 64'(awaddr_o), 64'(addr));
        awready = (aw_cnt == awd);
        aw_ok   = awready;
        aw_cnt++;
      end else begin
        awready = 1'b0;
        chk("awvalid_drop", 64'(awvalid_o), 64'd0);
      end
      if (!w_ok) begin
        chk("wvalid_hold", 64'(wvalid_o), 64'd1);
        chk("wdata", 64'(wdata_o), 64'(data));
        wready = (w_cnt == wd);
        w_ok   = wready;
        w_cnt++;
      end else begin
        wready = 1'b0;
        chk("wvalid_drop", 64'(wvalid_o), 64'd0);
      end
      @(negedge clk);
    end
    awready = 1'b0;
    wready  = 1'b0;
    chk("waitb_entry_cycle", 64'(cyc), 64'(entry));
    chk("awvalid_after", 64'(awvalid_o), 64'd0);
    chk("wvalid_after", 64'(wvalid_o), 64'd0);
    if (bd < int'(TO)) begin
      for (int k = 0; k <= bd; k++) begin
        chk("bready_wait", 64'(bready_o), 64'd1);
        if (k < bd) @(negedge clk);
      end
      bvalid  = 1'b1;
      bid_r   = bid;
      bresp_r = bresp;
      @(negedge clk);
      bvalid  = 1'b0;
      bid_r   = 4'($urandom);
      bresp_r = 2'($urandom);
    end else begin
      for (int k = 0; k < int'(TO); k++) begin
        chk("bready_wait_to", 64'(bready_o), 64'd1);
        @(negedge clk);
      end
    end
    chk("bready_after", 64'(bready_o), 64'd0);
    chk("cmd_ready_after", 64'(cmd_ready_o), 64'd1);
  endtask

  // Monitor: compares each completion against the scoreboard and checks held values.
  initial begin
    exp_t held;
    exp_t e;
    held.resp = 2'b00; held.id_err = 1'b0; held.to = 1'b0; held.cyc = 0;
    forever begin
      @(negedge clk);
      if (!areset) begin
        held.resp = 2'b00; held.id_err = 1'b0; held.to = 1'b0;
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_resp", 64'(resp_o), 64'd0);
        chk("rst_id_err", 64'(id_err_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
      end else if (done_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_done actual=done_o=1 expected=no completion (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("resp", 64'(resp_o), 64'(e.resp));
          chk("id_err", 64'(id_err_o), 64'(e.id_err));
          chk("timeout", 64'(timeout_o), 64'(e.to));
          held = e;
        end
      end else begin
        chk("resp_held", 64'(resp_o), 64'(held.resp));
        chk("id_err_held", 64'(id_err_o), 64'(held.id_err));
        chk("timeout_held", 64'(timeout_o), 64'(held.to));
      end
    end
  end

  initial begin
    #500000;
    bail("global_watchdog");
  end

  initial begin
    int bd;
    int r;
    logic [3:0] id;
    areset    = 1'b0;
    cmd_valid = 1'b0;
    cmd_id    = '0;
    cmd_addr  = '0;
    cmd_data  = '0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bid_r     = '0;
    bresp_r   = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("rst_awvalid", 64'(awvalid_o), 64'd0);
    chk("rst_wvalid", 64'(wvalid_o), 64'd0);
    chk("rst_bready", 64'(bready_o), 64'd0);
    chk("rst_awid", 64'(awid_o), 64'd0);
    chk("rst_awaddr", 64'(awaddr_o), 64'd0);
    chk("rst_wdata", 64'(wdata_o), 64'd0);
    #2 areset = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(cmd_ready_o), 64'd1);

    // Directed cases.
    do_txn(4'h3, 32'h1, 32'hABCDEF01, 0, 0, 0, 2'b00, 4'h3);
    do_txn(4'h7, 32'h100, 32'h12345678, 2, 0, 0, 2'b00, 4'h7);
    do_txn(4'h8, 32'h200, 32'h9ABCDEF0, 0, 2, 1, 2'b01, 4'h8);
    do_txn(4'h1, 32'h300, 32'h0BADF00D, 1, 1, 5, 2'b11, 4'h1);
    do_txn(4'h5, 32'h400, 32'hCAFEBABE, 0, 0, 0, 2'b00, 4'h6);
    do_txn(4'h2, 32'h500, 32'h55AA55AA, 0, 0, TO, 2'b00, 4'h2);
    do_txn(4'h4, 32'h600, 32'hAA55AA55, 0, 0, 2, 2'b00, 4'h4);
    do_txn(4'h9, 32'h700, 32'h13579BDF, 0, 1, TO - 1, 2'b01, 4'h9);

    // Reset while AW is stalled.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_id    = 4'hC;
    cmd_addr  = 32'hDEAD0000;
    cmd_data  = 32'h0000BEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_awvalid", 64'(awvalid_o), 64'd1);
    #2 areset = 1'b0;
    #1;
    chk("midrst_awvalid", 64'(awvalid_o), 64'd0);
    chk("midrst_wvalid", 64'(wvalid_o), 64'd0);
    chk("midrst_awaddr", 64'(awaddr_o), 64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    @(negedge clk);
    #2 areset = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", 64'(cmd_ready_o), 64'd1);
    do_txn(4'hD, 32'hF00, 32'h600DF00D, 0, 0, 0, 2'b00, 4'hD);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       bd = $urandom_range(0, TO - 1);
      else if (r == 7) bd = TO - 1;
      else             bd = TO;
      id = 4'($urandom);
      do_txn(id, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), bd,
             2'($urandom), ($urandom_range(0, 1) == 0) ? id : 4'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    summary_and_finish();
  end

endmodule
